rr_arb_4: RTL

Four-requester round-robin arbiter that drives the 2-bit `sel` of the `mux_4to1` datapath stage. It picks one active requester, holds the grant while that requester keeps its request asserted, and rotates priority on release so no source starves. Outputs are registered, so the mux select is glitch-free and stable for the whole grant.

---
 rtl/rr_arb_pkg.sv | 6 +
 rtl/rr_arb_4_pick.sv | 16 +
 rtl/rr_arb_4.sv | 61 ++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared sizes and state type for the 4-way round-robin arbiter
package rr_arb_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/rr_arb_4_pick.sv
// rr_pick_4: combinational rotating-priority picker (req, ptr -> found, idx)
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;
  assign rot   = N_REQ'({req, req} >> ptr);
  assign off   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign found = |req;
  assign idx   = ptr + off;
endmodule

// File: rtl/rr_arb_4.sv
// rr_arb_4: registered 4-requester round-robin arbiter; ports clk, rst, req[3:0] -> grant[3:0], sel[1:0], valid; optional hold limit via RR_ARB_HOLD_LIMIT_EN
module rr_arb_4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             valid
);
  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] idx;
  logic             found;
  logic             keep;
`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD) + 1;
  logic [HW-1:0] hold_cnt;
  assign keep = req[sel] && (hold_cnt != HW'(MAX_HOLD - 1));
`else
  assign keep = req[sel];
`endif
  // On release the old winner drops to lowest priority.
  assign pick_ptr = (state == GRANT) ? sel + 2'd1 : ptr;
  rr_pick_4 u_pick (.req(req), .ptr(pick_ptr), .found(found), .idx(idx));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      grant <= '0;
      sel   <= '0;
      valid <= 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_cnt <= '0;
`endif
    end else if (state == GRANT && keep) begin
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_cnt <= hold_cnt + 1'b1;
`endif
    end else begin
      if (state == GRANT) ptr <= sel + 2'd1;
      if (found) begin
        state <= GRANT;
        grant <= N_REQ'(1) << idx;
        sel   <= idx;
        valid <= 1'b1;
`ifdef RR_ARB_HOLD_LIMIT_EN
        hold_cnt <= '0;
`endif
      end else begin
        state <= IDLE;
        grant <= '0;
        valid <= 1'b0;
      end
    end
  end
endmodule
